// File: rtl/apb_key_ctrl.sv
// APB key controller: four asynchronous key inputs are synchronised, debounced
// on a programmable tick, turned into press/release events and queued in a
// small FIFO that software drains by reading the EVENT register.
`timescale 1ns/1ps
module apb_key_ctrl #(
  parameter int ADDRWIDTH  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [3:0]           keyIn,
  output logic                 KEYINT
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [ADDRWIDTH-3:0] A_CTRL = (ADDRWIDTH-2)'(0);
  localparam logic [ADDRWIDTH-3:0] A_DIV  = (ADDRWIDTH-2)'(1);
  localparam logic [ADDRWIDTH-3:0] A_STAT = (ADDRWIDTH-2)'(2);
  localparam logic [ADDRWIDTH-3:0] A_EVT  = (ADDRWIDTH-2)'(3);
  localparam logic [ADDRWIDTH-3:0] A_CLR  = (ADDRWIDTH-2)'(4);

  logic [ADDRWIDTH-3:0] word_addr;
  logic                 wr_en;
  logic                 rd_access;
  logic                 clr;

  logic                 en_reg;
  logic                 ie_reg;
  logic [15:0]          div_reg;
  logic [15:0]          presc_reg;
  logic                 tick;

  logic [3:0]           sync1_reg;
  logic [3:0]           sync2_reg;
  logic [3:0]           deb_reg;
  logic [3:0]           pend_reg;
  logic [3:0]           pval_reg;
  logic [3:0]           pend_set;
  logic [3:0]           pend_clr;
  logic [1:0]           stab_reg [4];

  logic [2:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 ovf_reg;
  logic                 keyint_reg;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 do_write;
  logic                 overflow;
  logic [1:0]           sel_idx;
  logic [2:0]           push_evt;
  logic [2:0]           head;
  logic [4:0]           count_ext;
  logic [3:0]           count_disp;

  // Address bits below word granularity and upper write-data bits are ignored.
  logic                 unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  assign word_addr = PADDR[ADDRWIDTH-1:2];
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign rd_access = PSEL & PENABLE & ~PWRITE;
  assign clr       = wr_en & (word_addr == A_CLR) & PWDATA[0];
  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign KEYINT    = keyint_reg;

  // Control and divider registers written from the APB bus
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_reg  <= 1'b0;
      ie_reg  <= 1'b0;
      div_reg <= 16'd0;
    end else if (wr_en) begin
      if (word_addr == A_CTRL) begin
        en_reg <= PWDATA[0];
        ie_reg <= PWDATA[1];
      end
      if (word_addr == A_DIV) div_reg <= PWDATA[15:0];
    end
  end

  // Prescaler producing a one-cycle debounce tick every DIV+1 clocks
  assign tick = en_reg & (presc_reg == div_reg);
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)     presc_reg <= 16'd0;
    else if (!en_reg) presc_reg <= 16'd0;
    else if (tick)    presc_reg <= 16'd0;
    else              presc_reg <= presc_reg + 16'd1;
  end

  // Two-flop synchroniser for the raw key inputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_reg <= 4'd0;
      sync2_reg <= 4'd0;
    end else begin
      sync1_reg <= keyIn;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic differ;
      assign differ       = sync2_reg[gi] ^ deb_reg[gi];
      assign pend_set[gi] = tick & differ & (stab_reg[gi] == 2'd2);

      // Stability counter, debounced level and pending-event flag for one key
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          stab_reg[gi] <= 2'd0;
          deb_reg[gi]  <= 1'b0;
          pend_reg[gi] <= 1'b0;
          pval_reg[gi] <= 1'b0;
        end else if (!en_reg) begin
          stab_reg[gi] <= 2'd0;
          pend_reg[gi] <= 1'b0;
        end else begin
          if (tick) begin
            if (!differ) begin
              stab_reg[gi] <= 2'd0;
            end else if (pend_set[gi]) begin
              stab_reg[gi] <= 2'd0;
              deb_reg[gi]  <= ~deb_reg[gi];
            end else begin
              stab_reg[gi] <= stab_reg[gi] + 2'd1;
            end
          end
          // A new event on the key wins over the scheduler clearing the old one
          if (pend_set[gi]) begin
            pend_reg[gi] <= 1'b1;
            pval_reg[gi] <= ~deb_reg[gi];
          end else if (pend_clr[gi]) begin
            pend_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Scheduler: lowest-index pending key is pushed, one per cycle
  always_comb begin
    sel_idx  = 2'd0;
    push     = 1'b0;
    pend_clr = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_reg[i]) begin
        sel_idx = 2'(i);
        push    = en_reg;
      end
    end
    if (push) pend_clr[sel_idx] = 1'b1;
    push_evt = {pval_reg[sel_idx], sel_idx};
  end

  assign full     = (count_reg == FULL_CNT);
  assign pop      = rd_access & (word_addr == A_EVT) & (count_reg != '0);
  assign do_write = push & (~full | pop);
  assign overflow = push & full & ~pop;
  assign head     = fifo_mem[rd_ptr_reg];

  // Event storage; contents need no reset since COUNT qualifies every read
  always_ff @(posedge PCLK) begin
    if (do_write) fifo_mem[wr_ptr_reg] <= push_evt;
  end

  // FIFO pointers, occupancy, sticky overflow and the interrupt register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      keyint_reg <= 1'b0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)      rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_write && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !do_write) count_reg <= count_reg - CW'(1);
      ovf_reg    <= (ovf_reg & ~clr) | overflow;
      keyint_reg <= ie_reg & ((count_reg != '0) | ovf_reg);
    end
  end

  // COUNT field is four bits wide, so a 16-deep FIFO saturates at 15
  assign count_ext  = 5'(count_reg);
  assign count_disp = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

  // Read data mux, driven while a read transfer is selected
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (word_addr)
        A_CTRL:  PRDATA = {30'd0, ie_reg, en_reg};
        A_DIV:   PRDATA = {16'd0, div_reg};
        A_STAT:  PRDATA = {23'd0, ovf_reg, count_disp, deb_reg};
        A_EVT:   if (count_reg != '0) PRDATA = {23'd0, 1'b1, 3'd0, head[2], 2'd0, head[1:0]};
        default: PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_key_ctrl.sv
// Self-checking bench for apb_key_ctrl: directed scenarios with literal
// expectations followed by randomized key activity and APB traffic, all
// compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_apb_key_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_DIV  = 12'h004;
  localparam logic [11:0] A_STAT = 12'h008;
  localparam logic [11:0] A_EVT  = 12'h00C;
  localparam logic [11:0] A_CLR  = 12'h010;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [11:0] PADDR = 12'd0;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  keyIn = 4'd0;
  logic        KEYINT;

  int checks = 0;
  int errors = 0;

  apb_key_ctrl #(.ADDRWIDTH(12), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .keyIn(keyIn), .KEYINT(KEYINT)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- behavioural model ----------------
  bit       m_en, m_ie, m_ovf, m_keyint;
  int       m_div, m_presc;
  bit [3:0] m_s1, m_s2, m_deb, m_pend, m_pval;
  int       m_stab [4];
  int       mq [$];

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_ovf = 0; m_keyint = 0;
    m_div = 0; m_presc = 0;
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_pend = 0; m_pval = 0;
    for (int i = 0; i < 4; i++) m_stab[i] = 0;
    mq.delete();
  endtask

  task automatic model_step();
    bit wr, rd_evt, clr, tick, push, pop, ovf_set, kint_n;
    int a, sel, ev;
    a      = int'(PADDR[11:2]);
    wr     = PSEL && PENABLE && PWRITE;
    rd_evt = PSEL && PENABLE && !PWRITE && (a == 3);
    clr    = wr && (a == 4) && PWDATA[0];
    kint_n = m_ie && (mq.size() != 0 || m_ovf);
    tick   = m_en && (m_presc == m_div);
    sel = -1;
    for (int i = 0; i < 4; i++) if (sel < 0 && m_pend[i]) sel = i;
    push = m_en && (sel >= 0);
    ev = 0;
    if (push) begin
      ev = 'h100 | (int'(m_pval[sel]) << 4) | sel;
      m_pend[sel] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (!m_en) begin
        m_stab[i] = 0;
        m_pend[i] = 0;
      end else if (tick) begin
        if (m_s2[i] != m_deb[i]) begin
          if (m_stab[i] == 2) begin
            m_deb[i]  = ~m_deb[i];
            m_stab[i] = 0;
            m_pend[i] = 1;
            m_pval[i] = m_deb[i];
          end else begin
            m_stab[i]++;
          end
        end else begin
          m_stab[i] = 0;
        end
      end
    end
    pop = rd_evt && (mq.size() > 0);
    ovf_set = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back(ev);
      else ovf_set = 1;
    end
    m_ovf    = (m_ovf && !clr) || ovf_set;
    m_keyint = kint_n;
    m_presc  = (!m_en || tick) ? 0 : ((m_presc + 1) & 'hFFFF);
    m_s2 = m_s1;
    m_s1 = keyIn;
    if (wr && a == 0) begin
      m_en = PWDATA[0];
      m_ie = PWDATA[1];
    end
    if (wr && a == 1) m_div = int'(PWDATA[15:0]);
  endtask

  function automatic logic [31:0] model_rd(logic [11:0] addr);
    int a, c;
    a = int'(addr[11:2]);
    c = (mq.size() > 15) ? 15 : mq.size();
    case (a)
      0: return {30'd0, m_ie, m_en};
      1: return 32'(m_div);
      2: return (32'(m_ovf) << 8) | (32'(c) << 4) | 32'(m_deb);
      3: return (mq.size() != 0) ? 32'(mq[0]) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) model_reset();
    else          model_step();
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: interrupt line, and read data during any access phase
  always @(negedge PCLK) begin
    check("keyint_model", KEYINT, m_keyint);
    if (PSEL && PENABLE && !PWRITE) check("prdata_model", PRDATA, model_rd(PADDR));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_wr(logic [11:0] a, logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    $display("WR addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic apb_rd(logic [11:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(negedge PCLK);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
    $display("RD addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESETn = 0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1;
    $display("RESET pulse");
  endtask

  logic [31:0] d;
  logic [11:0] rnd_addr [6] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014};

  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1;

    // Reset state
    apb_rd(A_STAT, d); check("rst_status", d, 32'h0);
    apb_rd(A_CTRL, d); check("rst_ctrl", d, 32'h0);
    apb_rd(A_EVT, d);  check("rst_event", d, 32'h0);
    check("rst_keyint", KEYINT, 32'h0);
    check("pready_pslverr", {PREADY, PSLVERR}, 32'h2);

    // Single press on key 0 with DIV=0
    apb_wr(A_DIV, 32'h0);
    apb_wr(A_CTRL, 32'h3);
    keyIn = 4'b0001;
    idle(12);
    apb_rd(A_STAT, d); check("press0_status", d, 32'h011);
    check("press0_keyint", KEYINT, 32'h1);
    apb_rd(A_EVT, d);  check("press0_event", d, 32'h110);
    idle(2);
    check("press0_keyint_clr", KEYINT, 32'h0);

    // Glitch shorter than three ticks at DIV=9 is filtered
    keyIn = 4'b0000;
    do_reset();
    apb_wr(A_DIV, 32'd9);
    apb_wr(A_CTRL, 32'h1);
    keyIn = 4'b0100;
    idle(15);
    keyIn = 4'b0000;
    idle(30);
    apb_rd(A_STAT, d); check("glitch_status", d, 32'h0);

    // All keys at once, then overflow with two releases
    do_reset();
    apb_wr(A_CTRL, 32'h3);
    keyIn = 4'hF;
    idle(15);
    apb_rd(A_STAT, d); check("allkeys_status", d, 32'h04F);
    keyIn = 4'b0011;
    idle(15);
    apb_rd(A_STAT, d); check("ovf_status", d, 32'h143);
    check("ovf_keyint", KEYINT, 32'h1);
    apb_wr(A_CLR, 32'h1);
    apb_rd(A_STAT, d); check("clr_status", d, 32'h043);
    for (int i = 0; i < 4; i++) begin
      apb_rd(A_EVT, d); check("ovf_pop", d, 32'h110 + 32'(i));
    end
    apb_rd(A_EVT, d); check("empty_pop", d, 32'h0);

    // Pop and push on the same edge while full
    keyIn = 4'b0000;
    do_reset();
    apb_wr(A_CTRL, 32'h3);
    keyIn = 4'hF;
    idle(15);
    keyIn = 4'b1110;
    repeat (3) @(posedge PCLK);
    apb_rd(A_EVT, d);  check("simul_pop", d, 32'h110);
    apb_rd(A_STAT, d); check("simul_status", d, 32'h04E);
    apb_rd(A_EVT, d);  check("simul_pop1", d, 32'h111);
    apb_rd(A_EVT, d);  check("simul_pop2", d, 32'h112);
    apb_rd(A_EVT, d);  check("simul_pop3", d, 32'h113);
    apb_rd(A_EVT, d);  check("simul_last", d, 32'h100);

    // Reset with three queued events discards them
    keyIn = 4'b0000;
    idle(15);
    apb_rd(A_STAT, d); check("three_status", d, 32'h030);
    do_reset();
    apb_rd(A_STAT, d); check("post_rst_status", d, 32'h0);
    apb_rd(A_EVT, d);  check("post_rst_event", d, 32'h0);
    check("post_rst_keyint", KEYINT, 32'h0);

    // Randomized traffic against the model
    apb_wr(A_DIV, 32'($urandom_range(0, 3)));
    apb_wr(A_CTRL, 32'h3);
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) begin
        keyIn = 4'($urandom);
        idle($urandom_range(1, 12));
      end else if (r < 58) begin
        apb_rd(A_EVT, d);
      end else if (r < 72) begin
        apb_rd(A_STAT, d);
      end else if (r < 78) begin
        apb_rd(rnd_addr[$urandom_range(0, 5)], d);
      end else if (r < 83) begin
        apb_wr(A_CLR, 32'($urandom_range(0, 1)));
      end else if (r < 86) begin
        apb_wr(A_CTRL, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : {30'd0, 1'($urandom), 1'b1});
      end else if (r < 88) begin
        apb_wr(A_DIV, 32'($urandom_range(0, 3)));
      end else if (r < 89) begin
        apb_wr(12'h014, $urandom);
      end else if (r < 90) begin
        do_reset();
        apb_wr(A_CTRL, 32'h3);
      end else begin
        idle($urandom_range(1, 6));
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
